ym2149_vgm_writer: RTL and testbench
====================================

// Module: ym2149_vgm_writer
// PURPOSE
//  Command-stream player that drives the PSG register-write port (reg/val/wr).
//  Consumes a VGM-subset byte stream over valid/ready, issues timed write strobes,
//  and executes wait commands in 44.1 kHz sample units. Sits between a byte
//  source (ROM/FIFO reader) and the ym2149 core's in_reg/in_val/in_wr inputs.
// PARAMETERS
//  SAMPLE_DIV  45  clocks per 44.1 kHz sample (2 MHz clock); must be >= 1
//  WR_HIGH     2   cycles out_wr is held high per write; must be >= 1
//  WR_LOW      2   cycles out_wr is held low after a write, before the next byte is fetched; must be >= 1
// PORTS
//  in_clk      in   1   system clock
//  in_rst_n    in   1   asynchronous active-low reset
//  in_enable   in   1   1 = run, 0 = pause
//  in_byte     in   8   command stream byte
//  in_valid    in   1   in_byte valid
//  out_ready   out  1   byte accepted on a cycle where in_valid && out_ready
//  out_reg     out  4   PSG register index
//  out_val     out  8   PSG register data
//  out_wr      out  1   write strobe; the PSG samples it on its rising edge
//  out_busy    out  1   1 in any state other than FETCH_OP, DONE or ERROR
//  out_done    out  1   end-of-stream (0x66) reached; sticky
//  out_err     out  1   unknown opcode seen; sticky
// BEHAVIOUR
//  Interface: one clock (in_clk). Reset is asynchronous and active-low (in_rst_n).
//  Reset values: out_ready=0, out_reg=0, out_val=0, out_wr=0, out_busy=0,
//   out_done=0, out_err=0. All counters are cleared. State = FETCH_OP.
//   Reset asserted mid-write or mid-wait aborts immediately; no strobe completes.
//  Opcodes:
//   A0 rr dd  write dd to register rr[3:0]. If rr[7:4]!=0, bytes are consumed, no strobe.
//   61 ll hh  wait {hh,ll} samples; 0 = no wait.
//   62        wait 735 samples.
//   63        wait 882 samples.
//   7n        wait n+1 samples.
//   66        go to DONE.
//   other     go to ERROR.
//  Transaction states: FETCH_OP, FETCH_A1, FETCH_A2, WRITE_HI, WRITE_LO, WAIT, DONE, ERROR.
//  Byte acceptance: out_ready = in_enable && state is FETCH_OP/FETCH_A1/FETCH_A2.
//   out_ready is registered from the next state and does not depend on in_valid.
//  Write timing: data byte accepted at cycle M.
//   out_reg/out_val update at M+1. out_wr is high for cycles M+1 .. M+WR_HIGH.
//   out_wr is low for WR_LOW cycles after that. out_ready is high again at M+1+WR_HIGH+WR_LOW.
//   out_reg/out_val hold until the next write is issued.
//  Wait timing: last byte of a wait command (count N) accepted at cycle M.
//   The sample divider restarts at M+1. out_ready is high again at M+1+N*SAMPLE_DIV.
//   Zero wait: the next state is FETCH_OP and out_ready is high at M+1.
//   The 16-bit sample counter never wraps; 0xFFFF is the maximum wait.
//  in_enable=0:
//   out_ready drops the next cycle.
//   The WAIT divider and sample counter freeze.
//   A WRITE_HI/WRITE_LO sequence in progress runs to completion; this keeps the PSG edge clean.
//  DONE and ERROR are terminal. out_ready=0. Leave only by reset.
//  in_valid is ignored whenever out_ready=0. in_byte is never sampled unless a handshake occurs.
// TESTING
//  1. A0 07 38 streamed, in_valid held high, SAMPLE_DIV=45 -> out_reg=7 and out_val=0x38.
//     out_wr is high 2 cycles, starting 1 cycle after the data byte. ready reasserts 5 cycles after the data byte.
//  2. 61 03 00 -> out_ready low for exactly 135 cycles.
//     71 -> low for 90 cycles. 61 00 00 -> ready back on the next cycle.
//  3. A0 1F 55 -> all 3 bytes accepted, out_wr stays 0, out_reg/out_val unchanged.
//  4. 62 with in_enable dropped for 100 cycles mid-wait -> total ready-low time is 735*45+100 cycles.
//  5. A0 08 0F 66, then more bytes -> one strobe, out_done=1, out_ready stays 0.
//     Opcode 0x55 -> out_err=1, halts.
//  6. in_rst_n pulsed low during WRITE_HI -> out_wr falls asynchronously, all outputs reset.
//     Then A0 00 10 -> normal write.

Source files
------------

// File: rtl/ym2149_vgm_writer.sv
// VGM-subset command player: fetches bytes over valid/ready, issues timed PSG
// register-write strobes and executes sample-count waits at 44.1 kHz.
module ym2149_vgm_writer #(
   parameter int SAMPLE_DIV = 45,
   parameter int WR_HIGH    = 2,
   parameter int WR_LOW     = 2
) (
   input  logic       in_clk,
   input  logic       in_rst_n,
   input  logic       in_enable,
   input  logic [7:0] in_byte,
   input  logic       in_valid,
   output logic       out_ready,
   output logic [3:0] out_reg,
   output logic [7:0] out_val,
   output logic       out_wr,
   output logic       out_busy,
   output logic       out_done,
   output logic       out_err
);

   typedef enum logic [2:0] {
      FETCH_OP, FETCH_A1, FETCH_A2, WRITE_HI, WRITE_LO, WAIT, DONE, ERROR
   } state_t;

   localparam int WR_MAX = (WR_HIGH > WR_LOW) ? WR_HIGH : WR_LOW;
   localparam int WCNT_W = (WR_MAX > 1) ? $clog2(WR_MAX) : 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   state_t            r_state;
   logic [7:0]        r_op;
   logic [7:0]        r_arg1;
   logic [15:0]       r_samples;
   logic [DIV_W-1:0]  r_div;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_ready;
   logic [3:0]        r_reg;
   logic [7:0]        r_val;
   logic              r_wr;

   state_t      w_next;
   logic        w_hs;
   logic        w_load_write;
   logic        w_load_wait;
   logic [15:0] w_wait_n;
   logic        w_div_wrap;

   assign w_hs       = in_valid && r_ready;
   assign w_div_wrap = (r_div == DIV_W'(SAMPLE_DIV - 1));

   always_comb begin
      w_next       = r_state;
      w_load_write = 1'b0;
      w_load_wait  = 1'b0;
      w_wait_n     = 16'd0;
      case (r_state)
         FETCH_OP: begin
            if (w_hs) begin
               case (in_byte)
                  8'hA0, 8'h61: w_next = FETCH_A1;
                  8'h62: begin
                     w_wait_n    = 16'd735;
                     w_load_wait = 1'b1;
                     w_next      = WAIT;
                  end
                  8'h63: begin
                     w_wait_n    = 16'd882;
                     w_load_wait = 1'b1;
                     w_next      = WAIT;
                  end
                  8'h66: w_next = DONE;
                  default: begin
                     if (in_byte[7:4] == 4'h7) begin
                        w_wait_n    = {12'h000, in_byte[3:0]} + 16'd1;
                        w_load_wait = 1'b1;
                        w_next      = WAIT;
                     end else begin
                        w_next = ERROR;
                     end
                  end
               endcase
            end
         end
         FETCH_A1: begin
            if (w_hs) w_next = FETCH_A2;
         end
         FETCH_A2: begin
            if (w_hs) begin
               if (r_op == 8'hA0) begin
                  // Register indices above 15 are swallowed without a strobe.
                  if (r_arg1[7:4] == 4'h0) begin
                     w_load_write = 1'b1;
                     w_next       = WRITE_HI;
                  end else begin
                     w_next = FETCH_OP;
                  end
               end else begin
                  w_wait_n = {in_byte, r_arg1};
                  if (w_wait_n == 16'd0) begin
                     w_next = FETCH_OP;
                  end else begin
                     w_load_wait = 1'b1;
                     w_next      = WAIT;
                  end
               end
            end
         end
         WRITE_HI: begin
            if (r_wcnt == WCNT_W'(WR_HIGH - 1)) w_next = WRITE_LO;
         end
         WRITE_LO: begin
            if (r_wcnt == WCNT_W'(WR_LOW - 1)) w_next = FETCH_OP;
         end
         WAIT: begin
            if (in_enable && w_div_wrap && (r_samples == 16'd1)) w_next = FETCH_OP;
         end
         DONE:    w_next = DONE;
         ERROR:   w_next = ERROR;
         default: w_next = ERROR;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state   <= FETCH_OP;
         r_op      <= 8'h00;
         r_arg1    <= 8'h00;
         r_samples <= 16'd0;
         r_div     <= '0;
         r_wcnt    <= '0;
         r_ready   <= 1'b0;
         r_reg     <= 4'h0;
         r_val     <= 8'h00;
         r_wr      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= in_enable &&
                    ((w_next == FETCH_OP) || (w_next == FETCH_A1) || (w_next == FETCH_A2));
         r_wr    <= (w_next == WRITE_HI);
         if (w_hs && (r_state == FETCH_OP)) r_op <= in_byte;
         if (w_hs && (r_state == FETCH_A1)) r_arg1 <= in_byte;
         if (w_load_write) begin
            r_reg <= r_arg1[3:0];
            r_val <= in_byte;
         end
         if (w_next != r_state) begin
            r_wcnt <= '0;
         end else if ((r_state == WRITE_HI) || (r_state == WRITE_LO)) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
         end
         // Divider and sample counter freeze while paused.
         if (w_load_wait) begin
            r_samples <= w_wait_n;
            r_div     <= '0;
         end else if ((r_state == WAIT) && in_enable) begin
            if (w_div_wrap) begin
               r_div     <= '0;
               r_samples <= r_samples - 16'd1;
            end else begin
               r_div <= r_div + DIV_W'(1);
            end
         end
      end
   end

   assign out_ready = r_ready;
   assign out_reg   = r_reg;
   assign out_val   = r_val;
   assign out_wr    = r_wr;
   assign out_busy  = !((r_state == FETCH_OP) || (r_state == DONE) || (r_state == ERROR));
   assign out_done  = (r_state == DONE);
   assign out_err   = (r_state == ERROR);

endmodule

// File: tb/tb_ym2149_vgm_writer.sv
// Directed bench for ym2149_vgm_writer: writes, waits, pause, terminal states
// and asynchronous reset during a strobe.
module tb_ym2149_vgm_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic [3:0] reg_o;
   logic [7:0] val_o;
   logic       wr;
   logic       busy;
   logic       done;
   logic       err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic acc_flag = 1'b0;
   int acc_cyc = 0;
   int wr_highs = 0;

   ym2149_vgm_writer #(.SAMPLE_DIV(45), .WR_HIGH(2), .WR_LOW(2)) dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_enable(enable), .in_byte(byte_in),
      .in_valid(valid), .out_ready(ready), .out_reg(reg_o), .out_val(val_o),
      .out_wr(wr), .out_busy(busy), .out_done(done), .out_err(err)
   );

   always #5 clk = ~clk;

   // Handshake flag captured from the pre-edge values of valid and ready.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      acc_flag <= valid && ready;
   end

   always @(negedge clk) if (wr) wr_highs <= wr_highs + 1;

   task automatic send_byte(input logic [7:0] b, input bit hold);
      bit got;
      got = 0;
      byte_in = b;
      valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (acc_flag) begin
            got = 1;
            break;
         end
      end
      acc_cyc = cyc;
      if (!hold) valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_%02h: byte never accepted within 200 cycles", b);
      end
   endtask

   task automatic wait_ready_low(input int limit, output int lows);
      lows = 0;
      while (lows < limit) begin
         @(negedge clk);
         if (ready) break;
         lows++;
      end
   endtask

   task automatic do_reset();
      valid = 1'b0;
      enable = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready, reg_o, val_o, wr, busy, done, err} !== 17'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %05h expected 00000",
                  {ready, reg_o, val_o, wr, busy, done, err});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      int m_op;
      send_byte(8'hA0, 1);
      m_op = acc_cyc;
      send_byte(8'h07, 1);
      send_byte(8'h38, 0);
      checks++;
      if (acc_cyc - m_op !== 2) begin
         errors++;
         $display("[TB] FAIL write_back_to_back: got %0d expected 2", acc_cyc - m_op);
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (wr !== (k <= 2)) begin
            errors++;
            $display("[TB] FAIL write_wr_k%0d: got %b expected %b", k, wr, (k <= 2));
         end
         checks++;
         if (ready !== (k == 5)) begin
            errors++;
            $display("[TB] FAIL write_ready_k%0d: got %b expected %b", k, ready, (k == 5));
         end
         if (k == 1) begin
            checks++;
            if ({reg_o, val_o, busy} !== {4'h7, 8'h38, 1'b1}) begin
               errors++;
               $display("[TB] FAIL write_data: got reg=%0h val=%02h busy=%b expected reg=7 val=38 busy=1",
                        reg_o, val_o, busy);
            end
         end
      end
   endtask

   task automatic test_wait();
      int lows;
      send_byte(8'h61, 1);
      send_byte(8'h03, 1);
      send_byte(8'h00, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wait_busy: got %b expected 1", busy);
      end
      wait_ready_low(1000, lows);
      lows++;
      checks++;
      if (lows !== 135) begin
         errors++;
         $display("[TB] FAIL wait_61_0003: got %0d low cycles expected 135", lows);
      end
      send_byte(8'h71, 0);
      wait_ready_low(1000, lows);
      checks++;
      if (lows !== 90) begin
         errors++;
         $display("[TB] FAIL wait_71: got %0d low cycles expected 90", lows);
      end
      send_byte(8'h61, 1);
      send_byte(8'h00, 1);
      send_byte(8'h00, 0);
      wait_ready_low(1000, lows);
      checks++;
      if (lows !== 0) begin
         errors++;
         $display("[TB] FAIL wait_zero: got %0d low cycles expected 0", lows);
      end
   endtask

   task automatic test_bad_reg();
      int lows;
      send_byte(8'hA0, 1);
      send_byte(8'h1F, 1);
      send_byte(8'h55, 0);
      wait_ready_low(10, lows);
      checks++;
      if (lows !== 0) begin
         errors++;
         $display("[TB] FAIL badreg_ready: got %0d low cycles expected 0", lows);
      end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if ({wr, reg_o, val_o} !== {1'b0, 4'h7, 8'h38}) begin
            errors++;
            $display("[TB] FAIL badreg_k%0d: got wr=%b reg=%0h val=%02h expected wr=0 reg=7 val=38",
                     k, wr, reg_o, val_o);
         end
      end
   endtask

   task automatic test_pause();
      int lows;
      int more;
      lows = 0;
      send_byte(8'h62, 0);
      repeat (1000) begin
         @(negedge clk);
         if (!ready) lows++;
      end
      enable = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (!ready) lows++;
      end
      enable = 1'b1;
      wait_ready_low(40000, more);
      lows += more;
      checks++;
      if (lows !== 735 * 45 + 100) begin
         errors++;
         $display("[TB] FAIL pause_wait: got %0d low cycles expected %0d", lows, 735 * 45 + 100);
      end
   endtask

   task automatic test_done_err();
      int highs;
      send_byte(8'hA0, 1);
      wr_highs = 0;
      send_byte(8'h08, 1);
      send_byte(8'h0F, 1);
      send_byte(8'h66, 0);
      byte_in = 8'hA0;
      valid = 1'b1;
      highs = 0;
      repeat (20) begin
         @(negedge clk);
         if (ready) highs++;
      end
      valid = 1'b0;
      checks++;
      if (highs !== 0) begin
         errors++;
         $display("[TB] FAIL done_ready: got %0d ready cycles expected 0", highs);
      end
      checks++;
      if ({done, err, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL done_flags: got done/err/busy=%b expected 100", {done, err, busy});
      end
      checks++;
      if ({wr_highs, reg_o, val_o} !== {32'd2, 4'h8, 8'h0F}) begin
         errors++;
         $display("[TB] FAIL done_write: got strobe_cycles=%0d reg=%0h val=%02h expected 2 8 0f",
                  wr_highs, reg_o, val_o);
      end
      do_reset();
      send_byte(8'h55, 0);
      byte_in = 8'h66;
      valid = 1'b1;
      highs = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) highs++;
      end
      valid = 1'b0;
      checks++;
      if ({done, err, highs} !== {1'b0, 1'b1, 32'd0}) begin
         errors++;
         $display("[TB] FAIL err_halt: got done=%b err=%b ready_cycles=%0d expected 0 1 0",
                  done, err, highs);
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      send_byte(8'hA0, 1);
      send_byte(8'h03, 1);
      send_byte(8'hAA, 0);
      checks++;
      if (wr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midwrite_strobe: got %b expected 1", wr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready, reg_o, val_o, wr, busy, done, err} !== 17'h0) begin
         errors++;
         $display("[TB] FAIL midwrite_reset: got %05h expected 00000",
                  {ready, reg_o, val_o, wr, busy, done, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'hA0, 1);
      send_byte(8'h00, 1);
      send_byte(8'h10, 0);
      @(negedge clk);
      checks++;
      if ({wr, reg_o, val_o} !== {1'b1, 4'h0, 8'h10}) begin
         errors++;
         $display("[TB] FAIL post_reset_write: got wr=%b reg=%0h val=%02h expected 1 0 10",
                  wr, reg_o, val_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wait();
      test_bad_reg();
      test_pause();
      test_done_err();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
